rgb_led_pwm_driver: RTL and testbench

//   Downstream stage of the 2-bit comparator.
//   - Consumes the one-hot red/green/blue compare flags.
//   - Drives three board LEDs with a shared, programmable PWM brightness.
//   - Enforces a minimum display (hold) time per colour, so a fast-changing

---
 rtl/rgb_led_pwm_driver.sv | 174 +++++++++++++++++
 tb/tb_rgb_led_pwm_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm_driver.sv
// RGB LED PWM driver: shows the one-hot compare flags on three LEDs with
// shared PWM brightness, a minimum per-colour hold time and a multi-hot flag.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   en                1 = display on, 0 = LEDs off / FSM to IDLE
//   red, green, blue  comparator flags
//   duty              PWM on-clocks per 2**CNT_W period
//   led_r/g/b         registered PWM LED drives
//   holding           1 while in HOLD state
//   err               1-clock pulse when a sampled flag code was multi-hot
module rgb_led_pwm_driver #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             red,
  input  logic             green,
  input  logic             blue,
  input  logic [CNT_W-1:0] duty,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             holding,
  output logic             err
);

  localparam int HC_W =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD =
    HC_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]       color_in;
  logic [2:0]       color_q;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty_q;
  logic [HC_W-1:0]  hold_cnt;

  logic pwm_on;
  logic active;
  logic changed;
  logic hold_done;
  logic load;
  logic dec;
  logic multi;

  assign pwm_on    = (pwm_cnt < duty_q);
  assign active    = (state_q != S_IDLE);
  assign changed   = (color_in != color_q);
  assign hold_done = (hold_cnt == '0);
  assign multi     = (color_in[2] & color_in[1])
                   | (color_in[2] & color_in[0])
                   | (color_in[1] & color_in[0]);

  // Flag sampling and multi-hot detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_in <= '0;
      err      <= 1'b0;
    end else begin
      color_in <= {red, green, blue};
      err      <= multi;
    end
  end

  // PWM counter; duty only changes at the period wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_W'(1);
      if (pwm_cnt == CNT_MAX) begin
        duty_q <= duty;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; en=0 wins over everything
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        state_d = S_HOLD;
      end
      (state_q == S_HOLD): begin
        if (hold_done) begin
          state_d = S_SHOW;
        end
      end
      (state_q == S_SHOW): begin
        if (changed) begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!en) begin
      state_d = S_IDLE;
    end
  end

  // FSM outputs and datapath controls
  always_comb begin
    load    = 1'b0;
    dec     = 1'b0;
    holding = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        load = en;
      end
      (state_q == S_HOLD): begin
        holding = 1'b1;
        dec     = en & ~hold_done;
      end
      (state_q == S_SHOW): begin
        load = en & changed;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // Latched colour and hold counter; an abandoned count just sits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q  <= '0;
      hold_cnt <= '0;
    end else if (load) begin
      color_q  <= color_in;
      hold_cnt <= HOLD_LOAD;
    end else if (dec) begin
      hold_cnt <= hold_cnt - HC_W'(1);
    end
  end

  // Registered LED drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
    end else begin
      led_r <= color_q[2] & pwm_on & active;
      led_g <= color_q[1] & pwm_on & active;
      led_b <= color_q[0] & pwm_on & active;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_driver.sv
// Bench for rgb_led_pwm_driver: directed scenarios plus random flags,
// checked cycle by cycle against a time-based reference model.
module tb_rgb_led_pwm_driver;

  localparam int CW   = 8;
  localparam int HC   = 8;
  localparam int PER  = 1 << CW;

  logic          clk;
  logic          rst;
  logic          en;
  logic          red;
  logic          green;
  logic          blue;
  logic [CW-1:0] duty;
  logic          led_r;
  logic          led_g;
  logic          led_b;
  logic          holding;
  logic          err;

  rgb_led_pwm_driver #(
    .CNT_W(CW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .red(red),
    .green(green),
    .blue(blue),
    .duty(duty),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b),
    .holding(holding),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  // Reference model: time since reset, colour shown and the cycle at
  // which its hold period ends.
  int          k;
  int          rel;
  bit          act;
  logic [2:0]  shown;
  logic [2:0]  prev_in;
  logic [CW-1:0] dlat;

  task automatic step();
    logic [4:0] e;
    logic [2:0] smp;
    bit on;
    bit inhold;
    e = '0;
    if (rst) begin
      k = 0; rel = 0; act = 0;
      shown = '0; prev_in = '0; dlat = '0;
    end else begin
      smp    = prev_in;
      on     = (k % PER) < int'(dlat);
      inhold = act && (k <= rel);
      e[4:2] = (act && on) ? shown : 3'b000;
      e[0]   = ($countones(smp) > 1);
      if (!en) begin
        act = 0;
      end else if (!act) begin
        act = 1; shown = smp; rel = k + HC;
      end else if (!inhold && smp != shown) begin
        shown = smp; rel = k + HC;
      end
      e[1] = act && (k < rel);
      if ((k % PER) == PER - 1) dlat = duty;
      prev_in = {red, green, blue};
      k++;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic flags(input logic [2:0] f);
    {red, green, blue} = f;
  endtask

  // Monitor: one output vector per clock
  initial begin
    logic [4:0] e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {led_r, led_g, led_b, holding, err};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL cycle_out t=%0t got=%b exp=%b (r g b hold err)",
                   $time, got, e);
        end
      end
    end
  end

  initial begin
    logic [2:0] f;
    logic [4:0] got;
    rst = 1'b1;
    en  = 1'b0;
    duty = '0;
    flags(3'b000);
    repeat (3) tick();
    rst = 1'b0;

    // Full brightness green
    en = 1'b1; duty = 8'd255; flags(3'b010);
    repeat (600) tick();

    // New duty mid-period
    repeat (100) tick();
    duty = 8'd64;
    repeat (600) tick();

    // red -> blue -> green, 2 clocks apart
    flags(3'b100); repeat (2) tick();
    flags(3'b001); repeat (2) tick();
    flags(3'b010); repeat (30) tick();

    // One-clock multi-hot
    flags(3'b110); tick();
    flags(3'b010); repeat (20) tick();

    // en dropped mid-HOLD then re-raised
    flags(3'b100); repeat (4) tick();
    en = 1'b0; repeat (5) tick();
    flags(3'b001);
    en = 1'b1; repeat (30) tick();

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 7) == 0) f = 3'($urandom);
        else f = 3'b001 << $urandom_range(0, 2);
        flags(f);
      end
      if ($urandom_range(0, 149) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 299) == 0) duty = CW'($urandom);
      tick();
    end

    // Async reset between edges while lit
    en = 1'b1; duty = 8'd255; flags(3'b010);
    repeat (300) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = {led_r, led_g, led_b, holding, err};
    tests++;
    if (got !== 5'b0) begin
      fails++;
      $display("FAIL async_rst got=%b exp=00000", got);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (300) tick();

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
